// File: rtl/switch_allocator.sv
// Wormhole switch allocator: each output round-robins over requesting inputs, checks
// downstream credit only at the packet head, and holds the path until the tail word.
module switch_allocator #(
    parameter int unsigned NUM_INPORTS  = 4,
    parameter int unsigned NUM_OUTPORTS = 4,
    parameter int unsigned NUM_VCS      = 2,
    localparam int unsigned IW = (NUM_INPORTS  > 1) ? $clog2(NUM_INPORTS)  : 1,
    localparam int unsigned OW = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
    localparam int unsigned VW = (NUM_VCS      > 1) ? $clog2(NUM_VCS)      : 1
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [NUM_INPORTS-1:0]               i_req_valid,
    input  logic [NUM_INPORTS-1:0][OW-1:0]       i_req_outport,
    input  logic [NUM_INPORTS-1:0][VW-1:0]       i_req_vc,
    input  logic [NUM_INPORTS-1:0]               i_flit_valid,
    input  logic [NUM_INPORTS-1:0]               i_flit_tail,
    input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] i_buffer_available,
    output logic [NUM_INPORTS-1:0]               o_grant,
    output logic [NUM_OUTPORTS-1:0]              o_out_enable,
    output logic [NUM_OUTPORTS-1:0][IW-1:0]      o_out_select,
    output logic [NUM_OUTPORTS-1:0][VW-1:0]      o_out_vc,
    output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] o_packet_sent
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                                r_state   [NUM_OUTPORTS];
    state_e                                w_state_d [NUM_OUTPORTS];
    logic   [NUM_OUTPORTS-1:0][IW-1:0]     r_sel;
    logic   [NUM_OUTPORTS-1:0][IW-1:0]     w_sel_d;
    logic   [NUM_OUTPORTS-1:0][VW-1:0]     r_vc;
    logic   [NUM_OUTPORTS-1:0][VW-1:0]     w_vc_d;
    logic   [NUM_OUTPORTS-1:0][IW-1:0]     r_ptr;
    logic   [NUM_OUTPORTS-1:0][IW-1:0]     w_ptr_d;

    logic   [NUM_INPORTS-1:0]              w_grant;
    logic   [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0] w_cand;
    logic   [NUM_OUTPORTS-1:0][NUM_VCS-1:0] w_packet_sent;
    logic   [NUM_OUTPORTS-1:0]             w_found;
    logic   [IW-1:0]                       w_idx;

    // An input is owned when any busy output has it selected.
    always_comb begin
        w_grant = '0;
        for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
            if (r_state[o] == StBusy) begin
                w_grant[r_sel[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_cand = '0;
        for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
            for (int unsigned i = 0; i < NUM_INPORTS; i++) begin
                w_cand[o][i] = i_req_valid[i] && !w_grant[i]
                            && (i_req_outport[i] == OW'(o))
                            && i_buffer_available[o][i_req_vc[i]];
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_sel_d       = r_sel;
        w_vc_d        = r_vc;
        w_ptr_d       = r_ptr;
        w_packet_sent = '0;
        w_found       = '0;
        w_idx         = '0;
        for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
            if (r_state[o] == StBusy) begin
                if (i_flit_valid[r_sel[o]]) begin
                    w_packet_sent[o][r_vc[o]] = 1'b1;
                    if (i_flit_tail[r_sel[o]]) begin
                        w_state_d[o] = StIdle;
                    end
                end
            end else begin
                // Circular search starting at the round-robin pointer.
                for (int unsigned k = 0; k < NUM_INPORTS; k++) begin
                    w_idx = IW'((32'(r_ptr[o]) + k) % NUM_INPORTS);
                    if (!w_found[o] && w_cand[o][w_idx]) begin
                        w_found[o]   = 1'b1;
                        w_state_d[o] = StBusy;
                        w_sel_d[o]   = w_idx;
                        w_vc_d[o]    = i_req_vc[w_idx];
                        w_ptr_d[o]   = IW'((32'(w_idx) + 1) % NUM_INPORTS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
                r_state[o] <= StIdle;
            end
            r_sel <= '0;
            r_vc  <= '0;
            r_ptr <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
                r_state[o] <= w_state_d[o];
            end
            r_sel <= w_sel_d;
            r_vc  <= w_vc_d;
            r_ptr <= w_ptr_d;
        end
    end

    always_comb begin
        o_out_enable = '0;
        for (int unsigned o = 0; o < NUM_OUTPORTS; o++) begin
            o_out_enable[o] = (r_state[o] == StBusy);
        end
    end

    assign o_grant       = w_grant;
    assign o_out_select  = r_sel;
    assign o_out_vc      = r_vc;
    assign o_packet_sent = w_packet_sent;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: the driver queues expected grant, release and word events;
// a negedge monitor pops and compares them as the allocator presents them.
module tb_switch_allocator;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int NV = 2;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic [NI-1:0]            req_valid;
    logic [NI-1:0][1:0]       req_outport;
    logic [NI-1:0][0:0]       req_vc;
    logic [NI-1:0]            flit_valid;
    logic [NI-1:0]            flit_tail;
    logic [NO-1:0][NV-1:0]    buffer_available;
    logic [NI-1:0]            grant;
    logic [NO-1:0]            out_enable;
    logic [NO-1:0][1:0]       out_select;
    logic [NO-1:0][0:0]       out_vc;
    logic [NO-1:0][NV-1:0]    packet_sent;

    typedef struct {
        int cyc;
        int o;
        int sel;
        int vc;
    } ev_t;

    ev_t q_grant[$];
    ev_t q_rel[$];
    ev_t q_sent[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    logic [NO-1:0]      prev_en = '0;
    logic [NO-1:0][1:0] prev_sel = '0;

    switch_allocator #(
        .NUM_INPORTS (NI),
        .NUM_OUTPORTS(NO),
        .NUM_VCS     (NV)
    ) u_dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .i_req_valid       (req_valid),
        .i_req_outport     (req_outport),
        .i_req_vc          (req_vc),
        .i_flit_valid      (flit_valid),
        .i_flit_tail       (flit_tail),
        .i_buffer_available(buffer_available),
        .o_grant           (grant),
        .o_out_enable      (out_enable),
        .o_out_select      (out_select),
        .o_out_vc          (out_vc),
        .o_packet_sent     (packet_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cyc=%0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input int o, input int sel, input int vc, input int c);
        q_grant.push_back('{c, o, sel, vc});
    endtask

    task automatic exp_r(input int o, input int c);
        q_rel.push_back('{c, o, 0, 0});
    endtask

    task automatic exp_s(input int o, input int v, input int c);
        q_sent.push_back('{c, o, 0, v});
    endtask

    task automatic req(input int i, input int o, input int v);
        req_valid[i]   = 1'b1;
        req_outport[i] = 2'(o);
        req_vc[i]      = 1'(v);
    endtask

    task automatic word(input int i, input bit tail);
        flit_valid[i] = 1'b1;
        flit_tail[i]  = tail;
    endtask

    task automatic idle_flits();
        flit_valid = '0;
        flit_tail  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  int'(grant),       0);
        chk({tag, "_enable"}, int'(out_enable),  0);
        chk({tag, "_select"}, int'(out_select),  0);
        chk({tag, "_vc"},     int'(out_vc),      0);
        chk({tag, "_sent"},   int'(packet_sent), 0);
    endtask

    // Monitor: grant/release edges on out_enable and every packet_sent bit pop a queue entry.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                for (int o = 0; o < NO; o++) begin
                    if (out_enable[o] && !prev_en[o]) begin
                        if (q_grant.size() == 0) begin
                            chk("grant_unexpected_out", o, -1);
                        end else begin
                            e = q_grant.pop_front();
                            chk("grant_out",    o,                    e.o);
                            chk("grant_cycle",  cyc,                  e.cyc);
                            chk("grant_select", int'(out_select[o]),  e.sel);
                            chk("grant_vc",     int'(out_vc[o]),      e.vc);
                            chk("grant_bit",    int'(grant[out_select[o]]), 1);
                        end
                    end
                    if (!out_enable[o] && prev_en[o]) begin
                        if (q_rel.size() == 0) begin
                            chk("release_unexpected_out", o, -1);
                        end else begin
                            e = q_rel.pop_front();
                            chk("release_out",   o,   e.o);
                            chk("release_cycle", cyc, e.cyc);
                            chk("release_grant_clear", int'(grant[prev_sel[o]]), 0);
                        end
                    end
                    for (int v = 0; v < NV; v++) begin
                        if (packet_sent[o][v]) begin
                            if (q_sent.size() == 0) begin
                                chk("sent_unexpected_outvc", o * NV + v, -1);
                            end else begin
                                e = q_sent.pop_front();
                                chk("sent_out",   o,   e.o);
                                chk("sent_vc",    v,   e.vc);
                                chk("sent_cycle", cyc, e.cyc);
                            end
                        end
                    end
                end
            end
            prev_en  = out_enable;
            prev_sel = out_select;
        end
    end

    initial begin
        int t;
        req_valid        = '0;
        req_outport      = '0;
        req_vc           = '0;
        flit_valid       = '0;
        flit_tail        = '0;
        buffer_available = '1;
        n_rst            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        n_rst  = 1'b1;
        mon_on = 1'b1;

        // Single request: input 1 -> outport 2, VC 0, three words.
        tick();
        t = cyc;
        req(1, 2, 0);
        exp_g(2, 1, 0, t + 1);
        tick(); req_valid[1] = 1'b0; word(1, 0); exp_s(2, 0, cyc);
        tick(); word(1, 0); exp_s(2, 0, cyc);
        tick(); word(1, 1); exp_s(2, 0, cyc); exp_r(2, cyc + 1);
        tick(); idle_flits();
        tick();

        // Round-robin: inputs 0, 1, 3 on outport 0 with single-word packets.
        tick();
        t = cyc;
        req(0, 0, 0); req(1, 0, 0); req(3, 0, 0);
        exp_g(0, 0, 0, t + 1);
        exp_g(0, 1, 0, t + 3);
        exp_g(0, 3, 0, t + 5);
        exp_g(0, 0, 0, t + 7);
        tick(); word(0, 1); exp_s(0, 0, cyc); exp_r(0, cyc + 1);
        tick(); idle_flits();
        tick(); word(1, 1); exp_s(0, 0, cyc); exp_r(0, cyc + 1);
        tick(); idle_flits();
        tick(); word(3, 1); exp_s(0, 0, cyc); exp_r(0, cyc + 1);
        tick(); idle_flits();
        tick(); word(0, 1); exp_s(0, 0, cyc); exp_r(0, cyc + 1); req_valid = '0;
        tick(); idle_flits();
        tick();

        // Credit gating: outport 1 VC 1 without credit for four cycles.
        tick();
        t = cyc;
        buffer_available[1][1] = 1'b0;
        req(2, 1, 1);
        exp_g(1, 2, 1, t + 5);
        repeat (4) tick();
        buffer_available[1][1] = 1'b1;
        tick();
        buffer_available[1][1] = 1'b0;
        req_valid[2] = 1'b0;
        word(2, 0); exp_s(1, 1, cyc);
        tick(); word(2, 1); exp_s(1, 1, cyc); exp_r(1, cyc + 1);
        tick(); idle_flits(); buffer_available = '1;
        tick();

        // Parallel outputs: 0 -> 0 on VC 1 and 3 -> 3 on VC 0.
        tick();
        t = cyc;
        req(0, 0, 1); req(3, 3, 0);
        exp_g(0, 0, 1, t + 1);
        exp_g(3, 3, 0, t + 1);
        tick(); req_valid = '0; word(0, 0); exp_s(0, 1, cyc);
        tick(); idle_flits(); word(3, 0); exp_s(3, 0, cyc);
        tick(); word(0, 1); word(3, 0);
        exp_s(0, 1, cyc); exp_s(3, 0, cyc); exp_r(0, cyc + 1);
        tick(); idle_flits(); word(3, 1); exp_s(3, 0, cyc); exp_r(3, cyc + 1);
        tick(); idle_flits();
        tick();

        // Stray words on ungranted inputs.
        tick();
        word(2, 1); word(1, 1);
        for (int k = 0; k < 3; k++) begin
            chk("stray_sent",   int'(packet_sent), 0);
            chk("stray_enable", int'(out_enable),  0);
            tick();
        end
        idle_flits();
        chk("stray_grant", int'(grant), 0);
        tick();

        // Reset mid-packet, then lowest-index requester wins after release.
        tick();
        t = cyc;
        req(1, 2, 1);
        exp_g(2, 1, 1, t + 1);
        tick(); req_valid = '0; word(1, 0); exp_s(2, 1, cyc);
        tick(); word(1, 0); exp_s(2, 1, cyc);
        tick();
        n_rst = 1'b0;
        exp_r(2, cyc);
        #1;
        chk_all_zero("midreset");
        idle_flits();
        tick();
        tick();
        n_rst = 1'b1;
        req(1, 2, 0); req(3, 2, 0);
        exp_g(2, 1, 0, cyc + 1);
        exp_g(2, 3, 0, cyc + 3);
        tick(); req_valid[1] = 1'b0; word(1, 1); exp_s(2, 0, cyc); exp_r(2, cyc + 1);
        tick(); idle_flits();
        tick(); req_valid[3] = 1'b0; word(3, 1); exp_s(2, 0, cyc); exp_r(2, cyc + 1);
        tick(); idle_flits();
        repeat (3) tick();

        chk("grant_events_left",   q_grant.size(), 0);
        chk("release_events_left", q_rel.size(),   0);
        chk("sent_events_left",    q_sent.size(),  0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
